// File: rtl/hit_judge_pkg.sv
// Shared constants for the hit judge: block height windows, lane state encoding,
// score increments and a popcount helper.
package hit_judge_pkg;

  localparam int H_W     = 10;
  localparam int H_OFF   = 720;
  localparam int HIT_LO  = 600;
  localparam int HIT_HI  = 680;
  localparam int PERF_LO = 630;
  localparam int PERF_HI = 650;

  localparam int PTS_PERFECT = 3;
  localparam int PTS_GOOD    = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [7:0] popcount(input logic [31:0] v);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) cnt = cnt + {7'd0, v[i]};
    return cnt;
  endfunction

endpackage

// File: rtl/hit_judge_lane.sv
// One lane of the judge: key edge detect, previous-height sample and the
// IDLE/ARMED/DONE tracker; emits this cycle's hit/perfect/miss decision.
module hit_judge_lane
  import hit_judge_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           restart,
  input  logic           hold,
  input  logic           key,
  input  logic [H_W-1:0] block_h,
  output logic           hit,
  output logic           perfect,
  output logic           miss
);

  localparam logic [H_W-1:0] H_OFF_V   = H_W'(H_OFF);
  localparam logic [H_W-1:0] HIT_LO_V  = H_W'(HIT_LO);
  localparam logic [H_W-1:0] HIT_HI_V  = H_W'(HIT_HI);
  localparam logic [H_W-1:0] PERF_LO_V = H_W'(PERF_LO);
  localparam logic [H_W-1:0] PERF_HI_V = H_W'(PERF_HI);

  logic           key_q;
  logic [H_W-1:0] h_q;
  logic [1:0]     state, state_nxt;
  logic           rise;

  assign rise = key & ~key_q;

  // Leaving the screen unjudged outranks everything; the hit window is only
  // consulted once the block is known to be neither gone nor past it.
  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    perfect   = 1'b0;
    miss      = 1'b0;
    if (!hold) begin
      case (state)
        ST_IDLE: begin
          if (block_h < H_OFF_V) state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (block_h == H_OFF_V) begin
            miss      = 1'b1;
            state_nxt = ST_IDLE;
          end else if (block_h > HIT_HI_V) begin
            miss      = 1'b1;
            state_nxt = ST_DONE;
          end else if (rise && block_h >= HIT_LO_V) begin
            hit       = 1'b1;
            perfect   = (block_h >= PERF_LO_V) && (block_h <= PERF_HI_V);
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (block_h == H_OFF_V)  state_nxt = ST_IDLE;
          else if (block_h < h_q)  state_nxt = ST_ARMED;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Edge/height history keeps sampling while held so a key held across
  // un-pause never looks like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= 1'b0;
      h_q   <= H_OFF_V;
      state <= ST_IDLE;
    end else if (restart) begin
      key_q <= 1'b0;
      h_q   <= H_OFF_V;
      state <= ST_IDLE;
    end else begin
      key_q <= key;
      h_q   <= block_h;
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Hit judge top: one tracker per lane, then per-cycle hit/miss tallies feeding
// the saturating score, combo, max combo and miss counters plus game_over.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int N_LANES   = 4,
  parameter int MAX_MISS  = 5,
  parameter int SCORE_MAX = 9999
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  input  logic                   pause,
  input  logic [N_LANES-1:0]     key,
  input  logic [10*N_LANES-1:0]  block_h,
  output logic [N_LANES-1:0]     hit_pulse,
  output logic [N_LANES-1:0]     perfect_pulse,
  output logic [N_LANES-1:0]     miss_pulse,
  output logic [13:0]            score,
  output logic [7:0]             combo,
  output logic [7:0]             max_combo,
  output logic [3:0]             miss_cnt,
  output logic                   game_over
);

  function automatic logic [13:0] sat_score(input logic [15:0] s);
    return (s > 16'(SCORE_MAX)) ? 14'(SCORE_MAX) : s[13:0];
  endfunction

  function automatic logic [7:0] sat_combo(input logic [8:0] s);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [3:0] sat_miss(input logic [7:0] s);
    return (s >= 8'(MAX_MISS)) ? 4'(MAX_MISS) : s[3:0];
  endfunction

  logic               hold;
  logic [N_LANES-1:0] lane_hit, lane_perf, lane_miss;

  assign hold = pause | game_over;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    hit_judge_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .hold    (hold),
      .key     (key[i]),
      .block_h (block_h[10*i +: 10]),
      .hit     (lane_hit[i]),
      .perfect (lane_perf[i]),
      .miss    (lane_miss[i])
    );
  end

  logic [7:0]  n_hit, n_perf, n_miss;
  logic [15:0] pts;
  logic [13:0] score_nxt;
  logic [7:0]  combo_nxt, max_nxt, miss_sum;
  logic [3:0]  miss_nxt;
  logic        over_nxt;

  // Lanes report nothing while held, so every counter naturally stands still.
  always_comb begin
    n_hit     = popcount(32'(lane_hit));
    n_perf    = popcount(32'(lane_perf));
    n_miss    = popcount(32'(lane_miss));
    pts       = 16'(n_perf) * 16'(PTS_PERFECT) + 16'(n_hit - n_perf) * 16'(PTS_GOOD);
    score_nxt = sat_score({2'b00, score} + pts);
    combo_nxt = (n_miss != 8'd0) ? 8'd0 : sat_combo({1'b0, combo} + {1'b0, n_hit});
    max_nxt   = (combo_nxt > max_combo) ? combo_nxt : max_combo;
    miss_sum  = {4'd0, miss_cnt} + n_miss;
    miss_nxt  = sat_miss(miss_sum);
    over_nxt  = game_over | (miss_sum >= 8'(MAX_MISS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_pulse     <= '0;
      perfect_pulse <= '0;
      miss_pulse    <= '0;
      score         <= '0;
      combo         <= '0;
      max_combo     <= '0;
      miss_cnt      <= '0;
      game_over     <= 1'b0;
    end else if (restart) begin
      hit_pulse     <= '0;
      perfect_pulse <= '0;
      miss_pulse    <= '0;
      score         <= '0;
      combo         <= '0;
      max_combo     <= '0;
      miss_cnt      <= '0;
      game_over     <= 1'b0;
    end else begin
      hit_pulse     <= lane_hit;
      perfect_pulse <= lane_perf;
      miss_pulse    <= lane_miss;
      score         <= score_nxt;
      combo         <= combo_nxt;
      max_combo     <= max_nxt;
      miss_cnt      <= miss_nxt;
      game_over     <= over_nxt;
    end
  end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Sits directly downstream of the falling-block lane generators.
- Consumes each lane's block_h together with the debounced piano keys, and judges every block as PERFECT, GOOD or MISS.
- Maintains score, combo, max combo and miss count, and asserts game_over once the miss limit is reached.
- game_over is ORed upstream into the lanes' stop_or_endgame so that blocks freeze.

Parameters:
- N_LANES, 4, number of lanes/keys.
- H_OFF, 720, block_h value meaning "no block on screen".
- HIT_LO, 600, lowest block_h accepted as a hit (inclusive).
- HIT_HI, 680, highest block_h accepted as a hit (inclusive); block_h > HIT_HI while armed = miss.
- PERF_LO, 630, PERFECT window low (inclusive).
- PERF_HI, 650, PERFECT window high (inclusive).
- MAX_MISS, 5, misses that end the game.
- SCORE_MAX, 9999, score saturation value.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- restart  in  1  synchronous clear of all game state, one-cycle or level.
- pause  in  1  freeze judgement; key edges ignored while high.
- key  in  N_LANES  debounced key levels, synchronous to clk.
- block_h  in  10*N_LANES  packed lane heights; lane i = bits [10*i+9:10*i].
- hit_pulse  out  N_LANES  one-cycle strobe per lane on a hit.
- perfect_pulse  out  N_LANES  one-cycle strobe; subset of hit_pulse.
- miss_pulse  out  N_LANES  one-cycle strobe per lane on a miss.
- score  out  14  accumulated score, saturating.
- combo  out  8  current combo, saturating at 255.
- max_combo  out  8  highest combo this game.
- miss_cnt  out  4  misses this game.
- game_over  out  1  sticky until restart or reset.

Behaviour:
- Reset and restart: all outputs 0, every lane in IDLE, key_q = 0, h_q = H_OFF.
  - restart is synchronous and outranks all other updates.
- Per-lane registers:
  - key_q = previous key sample; rise = key & ~key_q.
  - h_q = previous block_h sample.
- Per-lane FSM: IDLE, ARMED, DONE.
  - IDLE -> ARMED when block_h < H_OFF.
  - ARMED, rise and HIT_LO <= block_h <= HIT_HI -> hit_pulse; perfect_pulse too if PERF_LO <= block_h <= PERF_HI. Go to DONE.
  - ARMED, block_h > HIT_HI and block_h != H_OFF -> miss_pulse; go to DONE.
  - ARMED, rise with block_h < HIT_LO -> ignored; stay ARMED (no penalty).
  - ARMED, block_h == H_OFF without a judgement -> miss_pulse; go to IDLE.
  - DONE -> IDLE when block_h == H_OFF.
  - DONE -> ARMED when block_h < h_q (respawn detected).
  - Rises in IDLE or DONE are ignored.
- Judgement latency: evaluated on the rising edge at which rise is seen. Pulses and counters are registered on that edge; the pulse lasts exactly one cycle.
- pause = 1 or game_over = 1: FSMs, counters and pulses hold (pulses forced 0). key_q and h_q keep sampling, so a key held across un-pause does not produce a rise.
- Scoring within one cycle, summed across lanes:
  - PERFECT +3, GOOD +1.
  - Saturate at SCORE_MAX; use 16-bit intermediate sum.
- Combo within one cycle:
  - If any lane misses, combo = 0, even if other lanes hit in the same cycle.
  - Otherwise combo += number of hits, saturating at 255.
  - max_combo = max(max_combo, new combo), updated on the same edge.
- Misses:
  - miss_cnt += number of misses in the cycle, saturating at MAX_MISS.
  - game_over is set on the edge where the new miss_cnt >= MAX_MISS. Hits in that same cycle still score.
- Simultaneous hit and miss on one lane is impossible; the windows are disjoint.

Decomposition:
- Shared package `hit_judge_pkg`:
  - lane state enum (IDLE/ARMED/DONE);
  - H_OFF, window constants, score increments (PTS_PERFECT = 3, PTS_GOOD = 1).
- Sub-module `hit_judge_lane`, one per lane via generate:
  - contains key_q, h_q and the FSM;
  - outputs hit, perfect, miss.
- Top level holds the popcount/sum, the counters and game_over.

Test Plan:
- Lane 0: block_h ramps 120->720 by 1 per cycle; key rise at block_h = 640 -> perfect_pulse[0] and hit_pulse[0] for one cycle; score 3, combo 1.
- Lane 1: key rise at block_h = 610 -> hit_pulse[1] only; score +1. A second rise while in DONE has no effect.
- Lane 2: no key press; block_h passes 681 -> miss_pulse[2] at 681; combo 0; miss_cnt 1.
- Same cycle: lane 0 hit (perfect) and lane 3 miss -> score +3, combo 0, miss_cnt +1.
- Five misses accumulated -> game_over = 1 on the 5th miss; later key rises in window give no pulses and score is frozen. Then restart -> all outputs 0.
- Key held high through pause, block enters window, pause drops -> no hit. Block later passes 680 -> miss. Also assert rst_n low mid-game -> outputs 0 immediately, asynchronously.
